// File: rtl/exec_mem_stage.sv
// Execute/memory slice of a single-cycle RV32 datapath: ALU control decode, 32-bit ALU,
// word-organised data memory with combinational read, and write-back select.
module exec_mem_stage #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_LSB  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  aluop,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic        alusrc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  output logic [3:0]  aluctl,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] result
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  logic [31:0]     op_b;
  logic [IdxW-1:0] mem_idx;
  logic [31:0]     load_data;
  logic [31:0]     mem_q [MEM_WORDS];

  // Only funct7[5] distinguishes operations; the other bits are don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    aluctl = AluAdd;
    unique case (aluop)
      2'b00: aluctl = AluAdd;
      2'b01: aluctl = AluSub;
      default: begin
        unique case (funct3)
          // I-type has no SUB; funct7 there is part of the immediate.
          3'b000:  aluctl = (aluop == 2'b10 && funct7[5]) ? AluSub : AluAdd;
          3'b111:  aluctl = AluAnd;
          3'b110:  aluctl = AluOr;
          3'b100:  aluctl = AluXor;
          3'b001:  aluctl = AluSll;
          3'b101:  aluctl = funct7[5] ? AluSra : AluSrl;
          3'b010:  aluctl = AluSlt;
          3'b011:  aluctl = AluSltu;
          default: aluctl = AluAdd;
        endcase
      end
    endcase
  end

  assign op_b = alusrc ? imm : rs2_data;

  always_comb begin
    alu_out = 32'd0;
    case (aluctl)
      AluAdd:  alu_out = rs1_data + op_b;
      AluSub:  alu_out = rs1_data - op_b;
      AluAnd:  alu_out = rs1_data & op_b;
      AluOr:   alu_out = rs1_data | op_b;
      AluXor:  alu_out = rs1_data ^ op_b;
      AluSll:  alu_out = rs1_data << op_b[4:0];
      AluSrl:  alu_out = rs1_data >> op_b[4:0];
      AluSra:  alu_out = $signed(rs1_data) >>> op_b[4:0];
      AluSlt:  alu_out = {31'd0, $signed(rs1_data) < $signed(op_b)};
      AluSltu: alu_out = {31'd0, rs1_data < op_b};
      default: alu_out = 32'd0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  // Byte-offset and upper address bits are dropped, so accesses alias onto the array.
  assign mem_idx = alu_out[ADDR_LSB +: IdxW];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (memwrite) begin
      mem_q[mem_idx] <= rs2_data;
    end
  end

  assign load_data = memread ? mem_q[mem_idx] : 32'd0;
  assign result    = memtoreg ? load_data : alu_out;

endmodule

// File: tb/tb_exec_mem_stage.sv
// Randomised self-checking bench for exec_mem_stage against a behavioural model of the
// ALU decode, ALU arithmetic and a byte-addressed aliasing word memory.
module tb_exec_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  aluop;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        alusrc;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        memread, memwrite, memtoreg;
  logic [3:0]  aluctl;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];

  always #5 clk = ~clk;

  exec_mem_stage #(.MEM_WORDS(256), .ADDR_LSB(2)) dut (
    .clk(clk), .reset(reset), .aluop(aluop), .funct7(funct7), .funct3(funct3),
    .alusrc(alusrc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .aluctl(aluctl), .alu_out(alu_out), .zero(zero), .result(result)
  );

  // Expected ALU control code from the opcode/funct rules.
  function automatic logic [3:0] model_ctl(input logic [1:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'd0: return (op == 2'b10 && f7[5]) ? 4'b0110 : 4'b0010;
      3'd7: return 4'b0000;
      3'd6: return 4'b0001;
      3'd4: return 4'b0011;
      3'd1: return 4'b0100;
      3'd5: return f7[5] ? 4'b1000 : 4'b0101;
      3'd2: return 4'b0111;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    case (ctl)
      4'b0010: return a + b;
      4'b0110: return a + (~b + 32'd1);
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b1000: begin
        fill = 32'hFFFF_FFFF;
        fill = ~(fill >> sh);
        return (a >> sh) | (a[31] ? fill : 32'd0);
      end
      4'b0111: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b1001: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_index(input logic [31:0] addr);
    return int'((addr / 4) % 256);
  endfunction

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic mr, input logic mw, input logic m2r);
    aluop = op; funct7 = f7; funct3 = f3; alusrc = src;
    rs1_data = a; rs2_data = b; imm = im;
    memread = mr; memwrite = mw; memtoreg = m2r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] addr;
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      addr = $urandom;
      drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, addr, 1'b1, 1'b0, 1'b1);
      checks++;
      if (result !== 32'd0) begin
        errors++;
        $display("FAIL reset_load addr=%h got %h expected 0", addr, result);
      end
    end
    checks++;
    if (aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL reset_aluctl got %b expected 0010", aluctl);
    end
  endtask

  task automatic test_rtype();
    drive(2'b10, 7'h00, 3'b000, 1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd8 || zero !== 1'b0) begin
      errors++;
      $display("FAIL rtype_add got %0d/%b expected 8/0", alu_out, zero);
    end
    drive(2'b10, 7'h20, 3'b000, 1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd2 || aluctl !== 4'b0110) begin
      errors++;
      $display("FAIL rtype_sub got %0d ctl %b expected 2 ctl 0110", alu_out, aluctl);
    end
    drive(2'b10, 7'h00, 3'b111, 1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd1) begin
      errors++;
      $display("FAIL rtype_and got %0d expected 1", alu_out);
    end
    drive(2'b10, 7'h00, 3'b110, 1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd7 || result !== 32'd7) begin
      errors++;
      $display("FAIL rtype_or got %0d result %0d expected 7", alu_out, result);
    end
    // I-type funct3 000 ignores funct7[5]
    drive(2'b11, 7'h20, 3'b000, 1'b1, 32'd5, 32'd0, 32'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd8 || aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL itype_addi got %0d ctl %b expected 8 ctl 0010", alu_out, aluctl);
    end
  endtask

  task automatic test_branch();
    drive(2'b01, 7'h00, 3'b000, 1'b0, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (aluctl !== 4'b0110 || alu_out !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL branch_eq got ctl %b out %h zero %b expected 0110/0/1",
               aluctl, alu_out, zero);
    end
  endtask

  task automatic test_shift_cmp();
    drive(2'b10, 7'h20, 3'b101, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'hC000_0000) begin
      errors++;
      $display("FAIL sra got %h expected c0000000", alu_out);
    end
    drive(2'b10, 7'h00, 3'b101, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'h4000_0000) begin
      errors++;
      $display("FAIL srl got %h expected 40000000", alu_out);
    end
    drive(2'b10, 7'h00, 3'b010, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd1) begin
      errors++;
      $display("FAIL slt got %h expected 1", alu_out);
    end
    drive(2'b10, 7'h00, 3'b011, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd0) begin
      errors++;
      $display("FAIL sltu got %h expected 0", alu_out);
    end
  endtask

  task automatic test_store_load();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd1, 32'd8, 1'b1, 1'b1, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL store_before_edge got %h expected 0", result);
    end
    tick();
    model_mem[model_index(32'd8)] = 32'd1;
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd8, 1'b1, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL load_addr8 got %h expected 1", result);
    end
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd9, 1'b1, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL load_misaligned got %h expected 1", result);
    end
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL load_memread0 got %h expected 0", result);
    end
  endtask

  task automatic test_alias();
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'hDEAD_BEEF, 32'h400, 1'b0, 1'b1, 1'b0);
    tick();
    model_mem[model_index(32'h400)] = 32'hDEAD_BEEF;
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL alias_load got %h expected deadbeef", result);
    end
  endtask

  task automatic test_reset_priority();
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'h55, 32'h20, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'h20, 1'b1, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset_prio_load got %h expected 0", result);
    end
    // Earlier DEADBEEF store must be gone too
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears_old got %h expected 0", result);
    end
    drive(2'b00, 7'd0, 3'd0, 1'b1, 32'd0, 32'd0, 32'h20, 1'b0, 1'b0, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset_prio_noread got %h expected 0", result);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        src, mr, mw, m2r, rst;
    logic [31:0] a, b, im, bsel, exp_ctl_out, exp_res;
    logic [3:0]  exp_ctl;
    for (int it = 0; it < 300; it++) begin
      op  = 2'($urandom);
      f3  = 3'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      src = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
      b   = $urandom;
      im  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
      // Bias toward low addresses so loads revisit stored words
      if (op == 2'b00 && $urandom_range(0, 1) == 0) begin
        a  = 32'($urandom_range(0, 63)) * 4;
        im = 32'($urandom_range(0, 3)) * 32'h400 + 32'($urandom_range(0, 3));
      end
      mr  = 1'($urandom);
      mw  = ($urandom_range(0, 2) == 0);
      m2r = 1'($urandom);
      rst = ($urandom_range(0, 40) == 0);
      drive(op, f7, f3, src, a, b, im, mr, mw, m2r);
      bsel        = src ? im : b;
      exp_ctl     = model_ctl(op, f7, f3);
      exp_ctl_out = model_alu(exp_ctl, a, bsel);
      exp_res     = m2r ? (mr ? model_mem[model_index(exp_ctl_out)] : 32'd0) : exp_ctl_out;
      checks++;
      if (aluctl !== exp_ctl) begin
        errors++;
        $display("FAIL rand_aluctl it=%0d op=%b f7=%h f3=%b got %b expected %b",
                 it, op, f7, f3, aluctl, exp_ctl);
      end
      checks++;
      if (alu_out !== exp_ctl_out) begin
        errors++;
        $display("FAIL rand_alu_out it=%0d a=%h b=%h got %h expected %h",
                 it, a, bsel, alu_out, exp_ctl_out);
      end
      checks++;
      if (zero !== (exp_ctl_out == 32'd0)) begin
        errors++;
        $display("FAIL rand_zero it=%0d got %b expected %b", it, zero, exp_ctl_out == 0);
      end
      checks++;
      if (result !== exp_res) begin
        errors++;
        $display("FAIL rand_result it=%0d got %h expected %h", it, result, exp_res);
      end
      reset = rst;
      tick();
      reset = 1'b0;
      if (rst) begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
      end else if (mw) begin
        model_mem[model_index(exp_ctl_out)] = b;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_rtype();
    test_branch();
    test_shift_cmp();
    test_store_load();
    test_alias();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
